// File: rtl/iiitb_lifo.sv
// iiitb_lifo: 8-entry x 4-bit synchronous stack with registered pop data.
// Full pushes and empty pops are dropped, so the pointer never wraps.
module iiitb_lifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int PTR_W = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut,
  input  logic             RW,
  input  logic             EN,
  output logic             EMPTY,
  output logic             FULL
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] sp_r;
  logic [WIDTH-1:0] dout_r;
  logic [PTR_W-1:0] sp_m1_s;
  logic [AW-1:0]    wr_idx_s;
  logic [AW-1:0]    rd_idx_s;
  logic             push_s;
  logic             pop_s;

  // Pointer-derived indices, flags and the accepted operation for this cycle
  always_comb begin
    sp_m1_s  = sp_r - PTR_W'(1);
    wr_idx_s = sp_r[AW-1:0];
    rd_idx_s = sp_m1_s[AW-1:0];
    EMPTY    = (sp_r == PTR_W'(0));
    FULL     = (sp_r == PTR_W'(DEPTH));
    if (EN) begin
      push_s = ~RW & ~FULL;
      pop_s  = RW & ~EMPTY;
    end else begin
      push_s = 1'b0;
      pop_s  = 1'b0;
    end
  end

  // Stack storage, pointer and registered pop data
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      sp_r   <= '0;
      dout_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s) begin
      mem_r[wr_idx_s] <= dataIn;
      sp_r            <= sp_r + PTR_W'(1);
    end else if (pop_s) begin
      dout_r <= mem_r[rd_idx_s];
      sp_r   <= sp_m1_s;
    end else begin
      sp_r   <= sp_r;
      dout_r <= dout_r;
    end
  end

  assign dataOut = dout_r;

endmodule

// File: tb/tb_iiitb_lifo.sv
// Self-checking bench for iiitb_lifo: directed scenarios plus random traffic
// checked every cycle against a queue-based stack model.
module tb_iiitb_lifo;

  logic       Clk;
  logic       Rst;
  logic [3:0] dataIn;
  logic [3:0] dataOut;
  logic       RW;
  logic       EN;
  logic       EMPTY;
  logic       FULL;

  int         total;
  int         bad;
  int         stk[$];
  logic [3:0] mdl_out;

  iiitb_lifo dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .dataIn  (dataIn),
    .dataOut (dataOut),
    .RW      (RW),
    .EN      (EN),
    .EMPTY   (EMPTY),
    .FULL    (FULL)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic lit(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle, advance the model at the edge, compare at the falling edge
  task automatic step(input logic rst, input logic en, input logic rw, input logic [3:0] din);
    Rst = rst; EN = en; RW = rw; dataIn = din;
    @(posedge Clk);
    if (!rst) begin
      stk.delete();
      mdl_out = 4'h0;
    end else if (en && !rw && stk.size() < 8) begin
      stk.push_back(int'(din));
    end else if (en && rw && stk.size() > 0) begin
      mdl_out = 4'(stk.pop_back());
    end
    @(negedge Clk);
    total++;
    if (dataOut !== mdl_out || EMPTY !== (stk.size() == 0) || FULL !== (stk.size() == 8)) begin
      bad++;
      $display("FAIL cycle_cmp: got out=%h E=%b F=%b expected out=%h E=%b F=%b",
               dataOut, EMPTY, FULL, mdl_out, stk.size() == 0, stk.size() == 8);
    end
  endtask

  task automatic push(input logic [3:0] d); step(1'b1, 1'b1, 1'b0, d); endtask
  task automatic pop();                     step(1'b1, 1'b1, 1'b1, 4'h0); endtask

  initial begin
    int ph;
    total = 0; bad = 0; mdl_out = 4'h0;
    Rst = 1'b0; EN = 1'b0; RW = 1'b0; dataIn = 4'h0;
    @(negedge Clk);

    // 1: reset with a pending push
    step(1'b0, 1'b1, 1'b0, 4'hF);
    step(1'b0, 1'b1, 1'b0, 4'hF);
    lit("rst_out", dataOut, 0); lit("rst_empty", EMPTY, 1); lit("rst_full", FULL, 0);

    // 2: push/pop ordering
    for (int i = 0; i < 4; i++) begin
      push(4'(2 * i));
      lit("push_out_hold", dataOut, 0);
    end
    pop(); lit("pop1", dataOut, 6);
    pop(); lit("pop2", dataOut, 4);
    pop(); lit("pop3", dataOut, 2);
    pop(); lit("pop4", dataOut, 0);
    lit("pop4_empty", EMPTY, 1);

    // 3: full boundary
    for (int i = 1; i <= 8; i++) push(4'(i));
    lit("full_set", FULL, 1);
    push(4'h9);
    lit("full_hold", FULL, 1);
    pop(); lit("full_pop", dataOut, 8); lit("full_clr", FULL, 0);

    // 4: empty boundary
    for (int i = 0; i < 7; i++) pop();
    lit("drain_out", dataOut, 1); lit("drain_empty", EMPTY, 1);
    pop(); pop();
    lit("empty_pop_out", dataOut, 1); lit("empty_pop_flag", EMPTY, 1);
    push(4'hA); pop();
    lit("a_pop", dataOut, 10); lit("a_empty", EMPTY, 1);

    // 5: enable gating
    push(4'h3); push(4'h5);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 4'h0);
    lit("en_hold_out", dataOut, 10); lit("en_hold_empty", EMPTY, 0);
    pop(); lit("en_pop", dataOut, 5);

    // 6: reset mid-operation
    push(4'h7); push(4'h9);
    step(1'b0, 1'b1, 1'b1, 4'h0);
    lit("mid_rst_empty", EMPTY, 1); lit("mid_rst_out", dataOut, 0);
    pop(); lit("mid_rst_pop", dataOut, 0);

    // Random traffic in push-heavy and pop-heavy phases
    for (int i = 0; i < 600; i++) begin
      ph = (i / 50) % 2;
      step(($urandom_range(0, 59) != 0),
           ($urandom_range(0, 9) < 8),
           (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
